// File: rtl/dice_roller_pkg.sv
// Shared encodings and sizing helpers for the dice roller.
package dice_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SAMPLE = 1'b1;

    // Largest multiple of sides that fits in a byte; bytes at or above it are rejected.
    function automatic int accept_limit(input int sides);
        return (256 / sides) * sides;
    endfunction

    function automatic int tries_width(input int max_tries);
        return $clog2(max_tries + 1);
    endfunction

endpackage

// File: rtl/dice_roller_if.sv
// Roll request/response bundle between game logic (master) and the roller (slave).
interface dice_roller_if;

    logic [7:0] rand_in;
    logic       roll_req;
    logic       roll_busy;
    logic       roll_valid;
    logic [7:0] roll_value;
    logic       roll_fallback;

    modport master (
        output rand_in,
        output roll_req,
        input  roll_busy,
        input  roll_valid,
        input  roll_value,
        input  roll_fallback
    );

    modport slave (
        input  rand_in,
        input  roll_req,
        output roll_busy,
        output roll_valid,
        output roll_value,
        output roll_fallback
    );

endinterface

// File: rtl/dice_range_reduce.sv
// Combinational byte -> {accept, candidate 1..SIDES} for rejection sampling.
// Zero latency; no flow control.
module dice_range_reduce
    import dice_pkg::*;
#(
    parameter int SIDES = 6
) (
    input  logic [7:0] rand_in,
    output logic       accept,
    output logic [7:0] candidate
);

    localparam int LIMIT = accept_limit(SIDES);

    int r;

    assign r         = int'(rand_in);
    assign accept    = (r < LIMIT);
    assign candidate = 8'((r % SIDES) + 1);

endmodule

// File: rtl/dice_roller.sv
// Unbiased 1..SIDES roll from a random byte stream; result 2..MAX_TRIES+1 cycles after request.
// Requests are only taken when idle; roll_req during a roll is dropped. Optional NO_REPEAT_EN.
module dice_roller
    import dice_pkg::*;
#(
    parameter int SIDES     = 6,
    parameter int MAX_TRIES = 4
) (
    input  logic          clk,
    input  logic          reset,
    dice_roller_if.slave  dif
);

    localparam int TRIES_W = tries_width(MAX_TRIES);

    logic [0:0]         state;
    logic [TRIES_W-1:0] tries;
    logic               valid;
    logic [7:0]         value;
    logic               fallback;

    logic               accept;
    logic [7:0]         candidate;
    logic               take;
    logic               last_try;

    dice_range_reduce #(
        .SIDES     (SIDES)
    ) u_range_reduce (
        .rand_in   (dif.rand_in),
        .accept    (accept),
        .candidate (candidate)
    );

`ifdef NO_REPEAT_EN
    logic [7:0] last_value;

    // A repeat of the previous result is treated like an out-of-range byte.
    assign take = accept && (candidate != last_value);
`else
    assign take = accept;
`endif

    assign last_try = (tries == TRIES_W'(MAX_TRIES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            tries    <= '0;
            valid    <= 1'b0;
            value    <= 8'd0;
            fallback <= 1'b0;
`ifdef NO_REPEAT_EN
            last_value <= 8'd0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dif.roll_req) begin
                        state <= ST_SAMPLE;
                        tries <= '0;
                    end
                end
                ST_SAMPLE: begin
                    if (take || last_try) begin
                        value    <= candidate;
                        fallback <= !take;
                        valid    <= 1'b1;
                        state    <= ST_IDLE;
`ifdef NO_REPEAT_EN
                        last_value <= candidate;
`endif
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dif.roll_busy     = (state == ST_SAMPLE);
    assign dif.roll_valid    = valid;
    assign dif.roll_value    = value;
    assign dif.roll_fallback = fallback;

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller: directed scenarios plus randomized rolls checked against a
// per-roll model that picks the first acceptable byte from the bytes fed during the roll.
module tb_dice_roller;

    localparam int SIDES     = 6;
    localparam int MAX_TRIES = 4;
    localparam int LIMIT_TB  = (256 / SIDES) * SIDES;
`ifdef NO_REPEAT_EN
    localparam bit NOREP = 1'b1;
`else
    localparam bit NOREP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    logic [7:0] samp [MAX_TRIES];
    int         model_last;

    dice_roller_if dif ();

    dice_roller #(
        .SIDES     (SIDES),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dif   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of one roll given the bytes seen on each sample cycle.
    task automatic model_roll(output int idx, output int val, output bit fb);
        int v;
        idx = -1;
        val = 0;
        fb  = 1'b0;
        for (int i = 0; i < MAX_TRIES; i++) begin
            v = (int'(samp[i]) % SIDES) + 1;
            if (idx < 0 && int'(samp[i]) < LIMIT_TB && !(NOREP && v == model_last)) begin
                idx = i;
                val = v;
            end
        end
        if (idx < 0) begin
            idx = MAX_TRIES - 1;
            val = (int'(samp[MAX_TRIES-1]) % SIDES) + 1;
            fb  = 1'b1;
        end
        model_last = val;
    endtask

    task automatic run_roll(input string name, input bit poke);
        int exp_idx;
        int exp_val;
        bit exp_fb;
        bit got;
        model_roll(exp_idx, exp_val, exp_fb);
        @(negedge clk);
        dif.roll_req = 1'b1;
        dif.rand_in  = 8'($urandom);
        @(negedge clk);
        dif.roll_req = 1'b0;
        total_cnt++;
        if (dif.roll_busy !== 1'b1)
            $display("FAIL %s busy: got %b want 1", name, dif.roll_busy);
        else
            pass_cnt++;
        got = 1'b0;
        for (int c = 0; c < MAX_TRIES + 2; c++) begin
            if (c < MAX_TRIES)
                dif.rand_in = samp[c];
            else
                dif.rand_in = 8'($urandom);
            dif.roll_req = poke && (c == 0);
            @(negedge clk);
            dif.roll_req = 1'b0;
            if (dif.roll_valid === 1'b1) begin
                total_cnt++;
                if (got) begin
                    $display("FAIL %s extra_valid: got pulse at N+%0d want none", name, c + 2);
                end else if (c != exp_idx || int'(dif.roll_value) != exp_val
                             || dif.roll_fallback !== exp_fb) begin
                    $display("FAIL %s result: got lat N+%0d val %0d fb %b want lat N+%0d val %0d fb %b",
                             name, c + 2, dif.roll_value, dif.roll_fallback,
                             exp_idx + 2, exp_val, exp_fb);
                end else begin
                    pass_cnt++;
                end
                got = 1'b1;
            end
        end
        total_cnt++;
        if (!got)
            $display("FAIL %s timeout: got no roll_valid want one by N+%0d", name, MAX_TRIES + 1);
        else
            pass_cnt++;
        total_cnt++;
        if (int'(dif.roll_value) != exp_val)
            $display("FAIL %s hold: got %0d want %0d", name, dif.roll_value, exp_val);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        dif.roll_req = 1'b1;
        dif.rand_in  = 8'h11;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({dif.roll_busy, dif.roll_valid, dif.roll_value, dif.roll_fallback} !== 11'd0)
            $display("FAIL reset_outputs: got busy %b valid %b val %0d fb %b want all 0",
                     dif.roll_busy, dif.roll_valid, dif.roll_value, dif.roll_fallback);
        else
            pass_cnt++;
        dif.roll_req = 1'b0;
        reset        = 1'b0;
        model_last   = 0;
        @(negedge clk);
        total_cnt++;
        if (dif.roll_busy !== 1'b0 || dif.roll_valid !== 1'b0)
            $display("FAIL idle_no_req: got busy %b valid %b want 0 0", dif.roll_busy, dif.roll_valid);
        else
            pass_cnt++;
    endtask

    task automatic test_directed();
        for (int i = 0; i < MAX_TRIES; i++) samp[i] = 8'h11;
        run_roll("first_accept", 1'b0);
        total_cnt++;
        if (dif.roll_value !== 8'd6) $display("FAIL s1_value: got %0d want 6", dif.roll_value);
        else pass_cnt++;

        samp[0] = 8'd253;
        for (int i = 1; i < MAX_TRIES; i++) samp[i] = 8'd7;
        run_roll("one_reject", 1'b0);
        total_cnt++;
        if (dif.roll_value !== 8'd2) $display("FAIL s2_value: got %0d want 2", dif.roll_value);
        else pass_cnt++;

        for (int i = 0; i < MAX_TRIES; i++) samp[i] = 8'd255;
        run_roll("fallback", 1'b0);
        total_cnt++;
        if (dif.roll_value !== 8'd4 || dif.roll_fallback !== 1'b1)
            $display("FAIL s3_value: got %0d fb %b want 4 fb 1", dif.roll_value, dif.roll_fallback);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_sample();
        @(negedge clk);
        dif.roll_req = 1'b1;
        @(negedge clk);
        dif.roll_req = 1'b0;
        dif.rand_in  = 8'h11;
        reset        = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({dif.roll_busy, dif.roll_valid, dif.roll_value, dif.roll_fallback} !== 11'd0)
                $display("FAIL mid_reset_c%0d: got busy %b valid %b val %0d fb %b want all 0", c,
                         dif.roll_busy, dif.roll_valid, dif.roll_value, dif.roll_fallback);
            else
                pass_cnt++;
        end
        reset      = 1'b0;
        model_last = 0;
        for (int i = 0; i < MAX_TRIES; i++) samp[i] = 8'h11;
        run_roll("after_reset", 1'b0);
        total_cnt++;
        if (dif.roll_value !== 8'd6) $display("FAIL after_reset_value: got %0d want 6", dif.roll_value);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int exp_t [3];
        int exp_v [3];
        bit exp_f [3];
        int idx;
        int prev;
        int n;
        int t;
        for (int i = 0; i < MAX_TRIES; i++) samp[i] = 8'd0;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            model_roll(idx, exp_v[k], exp_f[k]);
            exp_t[k] = prev + 2 + idx;
            prev     = exp_t[k];
        end
        @(negedge clk);
        dif.roll_req = 1'b1;
        dif.rand_in  = 8'd0;
        n = 0;
        t = 0;
        while (n < 3 && t < 40) begin
            @(negedge clk);
            t++;
            if (dif.roll_valid === 1'b1) begin
                total_cnt++;
                if (t != exp_t[n] || int'(dif.roll_value) != exp_v[n] || dif.roll_fallback !== exp_f[n])
                    $display("FAIL b2b_roll%0d: got t %0d val %0d fb %b want t %0d val %0d fb %b",
                             n, t, dif.roll_value, dif.roll_fallback, exp_t[n], exp_v[n], exp_f[n]);
                else
                    pass_cnt++;
                n++;
                if (n == 3) dif.roll_req = 1'b0;
            end
        end
        dif.roll_req = 1'b0;
        total_cnt++;
        if (n != 3) $display("FAIL b2b_count: got %0d pulses want 3", n);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (dif.roll_busy !== 1'b0) $display("FAIL b2b_stop: got busy %b want 0", dif.roll_busy);
        else pass_cnt++;
    endtask

    task automatic test_no_repeat();
        for (int i = 0; i < MAX_TRIES; i++) samp[i] = 8'd17;
        run_roll("nr_first", 1'b0);
        samp[0] = 8'd17;
        for (int i = 1; i < MAX_TRIES; i++) samp[i] = 8'd18;
        run_roll("nr_second", 1'b0);
        total_cnt++;
        if (int'(dif.roll_value) != (NOREP ? 1 : 6) || dif.roll_fallback !== 1'b0)
            $display("FAIL nr_value: got %0d fb %b want %0d fb 0",
                     dif.roll_value, dif.roll_fallback, NOREP ? 1 : 6);
        else
            pass_cnt++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < MAX_TRIES; i++) begin
                if ($urandom_range(0, 2) == 0)
                    samp[i] = 8'(LIMIT_TB + $urandom_range(0, 255 - LIMIT_TB));
                else
                    samp[i] = 8'($urandom);
            end
            run_roll($sformatf("rand%0d", k), k[0]);
        end
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        model_last   = 0;
        reset        = 1'b1;
        dif.roll_req = 1'b0;
        dif.rand_in  = 8'd0;
        test_reset();
        test_directed();
        test_reset_mid_sample();
        test_back_to_back();
        test_no_repeat();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
